cache_mem_model: RTL and testbench

//  Parametrised backing-memory responder for the cache master port (o_m_* / i_m_*).

---
 rtl/cache_mem_model_if.sv | 24 ++
 rtl/cache_mem_model.sv | 174 +++++++++++++++++
 tb/tb_cache_mem_model.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_model_if.sv
// rtl/cache_mem_model_if.sv - cache master port bundle between a cache and its backing memory
interface cache_mem_model_if #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 26
);
  logic [ADDR_W-1:0]    m_addr;
  logic [LINE_W/32-1:0] m_byte_en;
  logic [LINE_W-1:0]    m_writedata;
  logic                 m_read;
  logic                 m_write;
  logic [LINE_W-1:0]    m_readdata;
  logic                 m_readdata_valid;
  logic                 m_waitrequest;

  modport master (
    output m_addr, m_byte_en, m_writedata, m_read, m_write,
    input  m_readdata, m_readdata_valid, m_waitrequest
  );

  modport slave (
    input  m_addr, m_byte_en, m_writedata, m_read, m_write,
    output m_readdata, m_readdata_valid, m_waitrequest
  );
endinterface

// File: rtl/cache_mem_model.sv
// rtl/cache_mem_model.sv - backing-memory responder for the cache master port
module cache_mem_model #(
  parameter int LINE_W       = 128,
  parameter int ADDR_W       = 26,
  parameter int DEPTH_LOG2   = 6,
  parameter int RD_LATENCY   = 2,
  parameter int WR_STALL     = 1,
  parameter int STALL_PERIOD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  cache_mem_model_if.slave m,
  output logic [31:0]      cnt_rd_o,
  output logic [31:0]      cnt_wr_o,
  output logic             err_o
);
  localparam int          WORDS      = LINE_W / 32;
  localparam int          DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [31:0] RD_LAST    = 32'(RD_LATENCY - 1);
  localparam logic [31:0] WR_LAST    = (WR_STALL > 0) ? 32'(WR_STALL - 1) : 32'd0;
  localparam bit          STALL_EN   = (STALL_PERIOD > 0);
  localparam logic [31:0] STALL_LAST = STALL_EN ? 32'(STALL_PERIOD - 1) : 32'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  logic [LINE_W-1:0]     mem_q [DEPTH];

  state_t                state_q, state_d;
  logic                  wait_q, wait_d;
  logic [31:0]           tmr_q, tmr_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  valid_q, valid_d;
  logic [LINE_W-1:0]     rdata_q, rdata_d;
  logic [31:0]           cnt_rd_q, cnt_rd_d;
  logic [31:0]           cnt_wr_q, cnt_wr_d;
  logic                  err_q, err_d;
  logic [31:0]           stl_q, stl_d;

  logic                  idle_cyc;
  logic                  stall;
  logic                  waitreq;
  logic                  acc;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  addr_hi_unused;

  // A cycle is idle when nothing is in flight; only idle cycles advance the stall counter
  assign idle_cyc = (state_q == IDLE) && !wait_q;
  assign stall    = STALL_EN && idle_cyc && (stl_q == STALL_LAST);
  assign waitreq  = wait_q | stall;

  // Write wins when both strobes are high; the read is dropped and flagged
  assign acc     = (m.m_read | m.m_write) && !waitreq;
  assign wr_acc  = acc && m.m_write;
  assign rd_acc  = acc && m.m_read && !m.m_write;
  assign acc_idx = m.m_addr[DEPTH_LOG2-1:0];

  // Upper address bits alias onto the same lines
  assign addr_hi_unused = ^m.m_addr[ADDR_W-1:DEPTH_LOG2];

  assign m.m_readdata       = rdata_q;
  assign m.m_readdata_valid = valid_q;
  assign m.m_waitrequest    = waitreq;
  assign cnt_rd_o           = cnt_rd_q;
  assign cnt_wr_o           = cnt_wr_q;
  assign err_o              = err_q;

  // Array write port: masked words land on the accept edge; storage is never reset
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int w = 0; w < WORDS; w++) begin
        if (m.m_byte_en[w]) begin
          mem_q[acc_idx][32*w +: 32] <= m.m_writedata[32*w +: 32];
        end
      end
    end
  end

  // State and response registers; reset drops any read still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wait_q   <= 1'b1;
      tmr_q    <= 32'd0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      rdata_q  <= '0;
      cnt_rd_q <= 32'd0;
      cnt_wr_q <= 32'd0;
      err_q    <= 1'b0;
      stl_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      tmr_q    <= tmr_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      rdata_q  <= rdata_d;
      cnt_rd_q <= cnt_rd_d;
      cnt_wr_q <= cnt_wr_d;
      err_q    <= err_d;
      stl_q    <= stl_d;
    end
  end

  // Next-state: accept in IDLE, count down read latency or write stall, then release
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    tmr_d    = tmr_q;
    idx_d    = idx_q;
    valid_d  = 1'b0;
    rdata_d  = rdata_q;
    cnt_rd_d = cnt_rd_q;
    cnt_wr_d = cnt_wr_q;
    err_d    = err_q;
    stl_d    = stl_q;

    if (STALL_EN && idle_cyc) begin
      stl_d = (stl_q == STALL_LAST) ? 32'd0 : stl_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        // Clears the post-reset hold on the first edge out of reset
        wait_d = 1'b0;
        if (rd_acc) begin
          state_d  = RD_WAIT;
          wait_d   = 1'b1;
          tmr_d    = RD_LAST;
          idx_d    = acc_idx;
          cnt_rd_d = cnt_rd_q + 32'd1;
        end else if (wr_acc) begin
          cnt_wr_d = cnt_wr_q + 32'd1;
          if (m.m_read) begin
            err_d = 1'b1;
          end
          if (WR_STALL > 0) begin
            state_d = WR_WAIT;
            wait_d  = 1'b1;
            tmr_d   = WR_LAST;
          end
        end
      end
      RD_WAIT: begin
        if (tmr_q == 32'd0) begin
          state_d = IDLE;
          wait_d  = 1'b0;
          valid_d = 1'b1;
          rdata_d = mem_q[idx_q];
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end
      WR_WAIT: begin
        if (tmr_q == 32'd0) begin
          state_d = IDLE;
          wait_d  = 1'b0;
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        wait_d  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_cache_mem_model.sv
// tb/tb_cache_mem_model.sv - randomized self-checking bench for cache_mem_model
module tb_cache_mem_model;
  localparam int LW = 128;
  localparam int AW = 26;
  localparam int NL = 64;
  localparam int RL = 2;
  localparam int WS = 1;
  localparam int SP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cnt_rd;
  logic [31:0] cnt_wr;
  logic        err;

  always #5 clk = ~clk;

  cache_mem_model_if #(.LINE_W(LW), .ADDR_W(AW)) ifc ();

  cache_mem_model #(
    .LINE_W(LW), .ADDR_W(AW), .DEPTH_LOG2(6),
    .RD_LATENCY(RL), .WR_STALL(WS), .STALL_PERIOD(SP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m        (ifc),
    .cnt_rd_o (cnt_rd),
    .cnt_wr_o (cnt_wr),
    .err_o    (err)
  );

  int n_pass   = 0;
  int n_checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: timeline in absolute cycle numbers
  bit [127:0] mdl_mem [NL];
  int         cyc = 0;
  int         free_at = 0;
  int         rd_due = 0;
  int         rd_idx = 0;
  int         idle_n = 0;
  bit         rd_pend = 0;
  bit         prev_idle = 0;
  bit         e_wait = 1;
  bit         e_valid = 0;
  bit         e_err = 0;
  bit [127:0] e_data = '0;
  bit [31:0]  e_rd = 0;
  bit [31:0]  e_wr = 0;

  always @(posedge clk) begin
    bit acc;
    bit idle;
    bit stall;
    int ix;
    cyc++;
    if (!rst_n) begin
      free_at   = cyc + 1;
      rd_pend   = 0;
      prev_idle = 0;
      idle_n    = 0;
      e_wait    = 1;
      e_valid   = 0;
      e_err     = 0;
      e_data    = '0;
      e_rd      = 0;
      e_wr      = 0;
    end else begin
      if (prev_idle) idle_n++;
      acc = (ifc.m_read || ifc.m_write) && !e_wait;
      ix  = int'(ifc.m_addr) % NL;
      e_valid = 0;
      if (rd_pend && cyc == rd_due) begin
        e_valid = 1;
        e_data  = mdl_mem[rd_idx];
        rd_pend = 0;
      end
      if (acc && ifc.m_write) begin
        for (int w = 0; w < LW / 32; w++)
          if (ifc.m_byte_en[w]) mdl_mem[ix][32*w +: 32] = ifc.m_writedata[32*w +: 32];
        e_wr++;
        if (ifc.m_read) e_err = 1;
        free_at = cyc + WS;
      end else if (acc) begin
        e_rd++;
        rd_idx  = ix;
        rd_due  = cyc + RL;
        rd_pend = 1;
        free_at = cyc + RL;
      end
      idle   = (cyc >= free_at);
      stall  = idle && ((idle_n % SP) == SP - 1);
      e_wait = !idle || stall;
      prev_idle = idle;
    end
    #1;
    chk("waitrequest", ifc.m_waitrequest, e_wait);
    chk("readdata_valid", ifc.m_readdata_valid, e_valid);
    chk("readdata", ifc.m_readdata, e_data);
    chk("cnt_rd", cnt_rd, e_rd);
    chk("cnt_wr", cnt_wr, e_wr);
    chk("err", err, e_err);
  end

  task automatic issue(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [3:0] en, input logic [127:0] d);
    bit ok;
    bit w;
    ok = 0;
    @(negedge clk);
    ifc.m_read      = rd;
    ifc.m_write     = wr;
    ifc.m_addr      = a;
    ifc.m_byte_en   = en;
    ifc.m_writedata = d;
    for (int i = 0; i < 16 && !ok; i++) begin
      w = ifc.m_waitrequest;
      @(posedge clk);
      if (!w) ok = 1;
      else @(negedge clk);
    end
    if (!ok) chk("accept_timeout", ok, 1);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    ifc.m_read  = 0;
    ifc.m_write = 0;
    repeat (n) @(posedge clk);
  endtask

  task automatic read_line(input logic [AW-1:0] a, output logic [127:0] d, output int lat);
    issue(1, 0, a, 4'h0, '0);
    @(negedge clk);
    ifc.m_read = 0;
    lat = -1;
    d   = '0;
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      if (ifc.m_readdata_valid) begin
        lat = k;
        d   = ifc.m_readdata;
      end
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [127:0] d;
    int           lat;
    bit           pat [5];
    int           r;
    pat = '{0, 0, 0, 1, 0};

    rst_n           = 0;
    ifc.m_read      = 0;
    ifc.m_write     = 0;
    ifc.m_addr      = '0;
    ifc.m_byte_en   = '0;
    ifc.m_writedata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wait", ifc.m_waitrequest, 1);
    chk("rst_valid", ifc.m_readdata_valid, 0);
    chk("rst_cnt_rd", cnt_rd, 0);
    chk("rst_cnt_wr", cnt_wr, 0);

    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall_pattern%0d", i), ifc.m_waitrequest, pat[i]);
    end

    for (int i = 0; i < NL; i++) issue(0, 1, AW'(i), 4'hF, rnd128());

    issue(0, 1, 26'd5, 4'hF, 128'h0123456789ABCDEF_0123456789ABCDEF);
    read_line(26'd5, d, lat);
    chk("full_write_lat", lat, 2);
    chk("full_write_data", d, 128'h0123456789ABCDEF_0123456789ABCDEF);
    chk("first_cnt_rd", cnt_rd, 1);

    issue(0, 1, 26'd5, 4'h2, 128'h11111111_22222222_DEADBEEF_33333333);
    read_line(26'd5, d, lat);
    chk("masked_write_data", d, 128'h0123456789ABCDEF_DEADBEEF_89ABCDEF);

    read_line(26'h45, d, lat);
    chk("alias_data", d, 128'h0123456789ABCDEF_DEADBEEF_89ABCDEF);

    issue(1, 1, 26'd7, 4'hF, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0);
    idle(2);
    #1;
    chk("err_set", err, 1);
    read_line(26'd7, d, lat);
    chk("rw_write_landed", d, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 15);
      if (r < 6)       issue(1, 0, AW'($urandom), 4'h0, rnd128());
      else if (r < 13) issue(0, 1, AW'($urandom), 4'($urandom_range(0, 15)), rnd128());
      else if (r == 13) issue(1, 1, AW'($urandom), 4'($urandom_range(0, 15)), rnd128());
      else             idle($urandom_range(1, 3));
    end
    idle(4);
    #1;
    chk("err_sticky", err, 1);

    issue(0, 1, 26'd9, 4'hF, 128'hCAFEF00D_0BADC0DE_FEEDFACE_13579BDF);
    issue(1, 0, 26'd9, 4'h0, '0);
    @(negedge clk);
    rst_n      = 0;
    ifc.m_read = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("reset_drop_valid%0d", i), ifc.m_readdata_valid, 0);
    end
    chk("reset_err", err, 0);
    chk("reset_cnt_rd", cnt_rd, 0);
    @(negedge clk);
    rst_n = 1;
    read_line(26'd9, d, lat);
    chk("post_reset_lat", lat, 2);
    chk("post_reset_data", d, 128'hCAFEF00D_0BADC0DE_FEEDFACE_13579BDF);

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
